// File: rtl/sha256_stream_core.sv
// Sequential SHA-256 core: internal padding, one compression round per clock.
// Define SHA256_DOUBLE_HASH_EN to hash the first digest again (SHA256d).
module sha256_stream_core #(
   parameter int MSG_BITS = 640
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MSG_BITS-1:0] msg,
   input  logic [255:0]        init_hash,
   input  logic [2047:0]       k_table,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [255:0]        digest,
   output logic                busy
);
   localparam int NBLK     = (MSG_BITS + 64) / 512 + 1;
   localparam int PAD_BITS = NBLK * 512;
   localparam int ZBITS    = PAD_BITS - MSG_BITS - 65;
   localparam int BW       = $clog2(NBLK + 1);
   localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_ADD, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [5:0]          rnd_q;
   logic [BW-1:0]       blk_q;
   logic [31:0]         hv_q [8];
   logic [31:0]         wk_q [8];
   logic [31:0]         w_q  [16];
   logic [MSG_BITS-1:0] msg_q;
`ifdef SHA256_DOUBLE_HASH_EN
   logic                dbl_q;
   logic [255:0]        mid_q;
   logic [255:0]        init_q;
`endif

   logic [PAD_BITS-1:0] padded;
   logic [511:0]        blk_data;
   logic [31:0]         k_t, t1, t2, w_new;
   logic [31:0]         h_sum [8];
   logic [255:0]        h_cat, sum_cat;
   logic                last_pass;

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction
   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction
   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction
   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
   endfunction

   assign padded = {msg_q, 1'b1, {ZBITS{1'b0}}, 64'(MSG_BITS)};

   always_comb begin
      blk_data = padded[PAD_BITS-1 -: 512];
      for (int i = 1; i < NBLK; i++) begin
         if (blk_q == BW'(i)) blk_data = padded[PAD_BITS-1-i*512 -: 512];
      end
`ifdef SHA256_DOUBLE_HASH_EN
      if (dbl_q) blk_data = {mid_q, 1'b1, 191'd0, 64'd256};
      last_pass = (blk_q == LAST_BLK) && dbl_q;
`else
      last_pass = (blk_q == LAST_BLK);
`endif
      // ~rnd_q is 63-t, so K[t] sits at bit offset (63-t)*32
      k_t   = k_table[{~rnd_q, 5'd0} +: 32];
      t1    = wk_q[7] + big_sigma1(wk_q[4]) + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
              + k_t + w_q[0];
      t2    = big_sigma0(wk_q[0]) + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
      w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
      for (int i = 0; i < 8; i++) h_sum[i] = hv_q[i] + wk_q[i];
      h_cat   = {hv_q[0], hv_q[1], hv_q[2], hv_q[3], hv_q[4], hv_q[5], hv_q[6], hv_q[7]};
      sum_cat = {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
   end

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_LOAD;
         S_LOAD:  state_d = S_ROUND;
         S_ROUND: if (rnd_q == 6'd63) state_d = S_ADD;
         S_ADD:   state_d = last_pass ? S_DONE : S_LOAD;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rnd_q   <= '0;
         blk_q   <= '0;
         msg_q   <= '0;
         for (int i = 0; i < 8; i++) begin
            hv_q[i] <= '0;
            wk_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
`ifdef SHA256_DOUBLE_HASH_EN
         dbl_q  <= 1'b0;
         mid_q  <= '0;
         init_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: if (in_valid) begin
               msg_q <= msg;
               rnd_q <= '0;
               blk_q <= '0;
               for (int i = 0; i < 8; i++) begin
                  hv_q[i] <= init_hash[255-32*i -: 32];
                  wk_q[i] <= init_hash[255-32*i -: 32];
               end
`ifdef SHA256_DOUBLE_HASH_EN
               dbl_q  <= 1'b0;
               init_q <= init_hash;
`endif
            end
            S_LOAD: begin
               for (int i = 0; i < 16; i++) w_q[i] <= blk_data[511-32*i -: 32];
               for (int i = 0; i < 8; i++) wk_q[i] <= hv_q[i];
            end
            S_ROUND: begin
               wk_q[0] <= t1 + t2;
               wk_q[1] <= wk_q[0];
               wk_q[2] <= wk_q[1];
               wk_q[3] <= wk_q[2];
               wk_q[4] <= wk_q[3] + t1;
               wk_q[5] <= wk_q[4];
               wk_q[6] <= wk_q[5];
               wk_q[7] <= wk_q[6];
               for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
               w_q[15] <= w_new;
               rnd_q   <= rnd_q + 6'd1;
            end
            S_ADD: begin
               for (int i = 0; i < 8; i++) hv_q[i] <= h_sum[i];
               if (blk_q != LAST_BLK) blk_q <= blk_q + BW'(1);
`ifdef SHA256_DOUBLE_HASH_EN
               else if (!dbl_q) begin
                  dbl_q <= 1'b1;
                  mid_q <= sum_cat;
                  for (int i = 0; i < 8; i++) hv_q[i] <= init_q[255-32*i -: 32];
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign digest    = out_valid ? h_cat : 256'd0;

endmodule
